mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Y86-64 SEQ memory stage, directly downstream of the execute block.
- Consumes icode/valE/valA/valP plus fetch error flags, then performs the data-memory read or write.
- Produces valM and the processor status code for writeback and PC update.
- Valid/ready handshake on both sides; a sticky halt state stops the machine after any non-AOK status.

Parameters:
MEM_BYTES, 1024, data memory size in bytes (byte-addressed, little-endian).
DATA_W, 64, word width in bits.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream operands valid
in_ready  output  1  stage can accept operands
icode  input  4  instruction code
valE  input  64  ALU result from execute
valA  input  64  register A value from decode
valP  input  64  incremented PC from fetch
imem_error  input  1  fetch address error
func_error  input  1  invalid instruction or function
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
valM  output  64  memory read data
stat  output  2  status: 0 AOK, 1 HLT, 2 ADR, 3 INS
dmem_error  output  1  data address out of range
icode_o  output  4  captured icode
valE_o  output  64  captured valE

Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.

Behaviour:
- FSM states: IDLE, ACCESS, RESP, HALTED.
- in_ready = (state==IDLE). out_valid = (state==RESP).
- Reset (async, any state): state=IDLE, valM=0, stat=AOK, dmem_error=0, icode_o=0, valE_o=0. Memory contents are not cleared.
- IDLE: on in_valid&&in_ready, capture all inputs and go to ACCESS.
- ACCESS (one cycle):
  - Address select: valE for icode 4, 5, 8, A; valA for icode 9, B.
  - Write data: valA for icode 4, A; valP for icode 8.
  - Read for icode 5, 9, B.
  - dmem_error = mem op && (addr > MEM_BYTES-8), compared as a 64-bit unsigned value.
  - stat priority: imem_error or dmem_error -> ADR; else func_error -> INS; else icode==0 -> HLT; else AOK.
  - The write commits at the clock edge leaving ACCESS, only if stat==AOK.
  - valM is registered on the same edge: read data, or 0 when there is no read or an error.
  - Go to RESP.
- RESP:
  - Outputs are held stable while out_ready=0.
  - On out_ready: go to IDLE if stat==AOK, else go to HALTED.
- HALTED: in_ready=0, outputs hold their last values; only reset exits.
- Latency: operands accepted at edge N; out_valid high after edge N+1; earliest next accept is edge N+3.
- Reset asserted during ACCESS: no write occurs.
- Non-memory icodes (0–3, 6, 7): no access, valM=0.
- Word access is 8 bytes: byte addr holds bits [7:0], addr+7 holds bits [63:56].

Decomposition:
- y86_pkg:
  - icode constants: IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B.
  - stat encodings.
  - FSM state encoding.
- Sub-module data_mem:
  - Byte array of size MEM_BYTES.
  - 8-byte little-endian synchronous write and registered read.
  - Bounds-check output.

Test Plan:
- rmmovq: icode=4, valE=16, valA=0x1122334455667788 -> stat AOK, byte[16]=0x88. Then mrmovq: icode=5, valE=16 -> valM=0x1122334455667788.
- pushq: icode=A, valE=1016, valA=7 -> AOK. Then popq: icode=B, valA=1016 -> valM=7 (read address comes from valA).
- call: icode=8, valE=1017, valP=0x40 -> dmem_error=1, stat=ADR, bytes 1017–1023 unchanged; after out_ready, in_ready stays 0 (HALTED) until rst_n pulse.
- halt: icode=0 -> stat=HLT, valM=0, HALTED. Also imem_error=1 with func_error=1 -> stat=ADR (priority check).
- Backpressure: out_ready held 0 for 3 cycles -> out_valid=1, valM and stat stable, in_ready=0; release -> IDLE next cycle.
- rst_n pulsed low while in ACCESS with an rmmovq (valE=32) pending -> outputs reset immediately, byte[32] keeps its prior value.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the memory stage: icodes, status codes,
// FSM states, captured operand payload and icode classification helpers.
package y86_pkg;

    localparam int unsigned WORD_W = 64;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0]        icode;
        logic [WORD_W-1:0] valE;
        logic [WORD_W-1:0] valA;
        logic [WORD_W-1:0] valP;
        logic              imem_error;
        logic              func_error;
    } mem_req_t;

    function automatic logic is_mem(input logic [3:0] ic);
        logic r;
        r = 1'b0;
        case (ic)
            IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: r = 1'b1;
            IHALT, INOP, IRRMOVQ, IIRMOVQ, IOPQ, IJXX:    r = 1'b0;
            default:                                      r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_read(input logic [3:0] ic);
        return (ic == IMRMOVQ) || (ic == IRET) || (ic == IPOPQ);
    endfunction

    function automatic logic is_write(input logic [3:0] ic);
        return (ic == IRMMOVQ) || (ic == IPUSHQ) || (ic == ICALL);
    endfunction

    // ret/popq address the stack through valA; everything else uses valE
    function automatic logic addr_from_vala(input logic [3:0] ic);
        return (ic == IRET) || (ic == IPOPQ);
    endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-addressed little-endian data memory: word-wide synchronous write,
// registered read and a combinational out-of-range flag.
module data_mem #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned DATA_W    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wr_en,
    input  logic              access,
    input  logic              rd,
    output logic              oob_c,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned AW = $clog2(MEM_BYTES);
    localparam int unsigned NB = DATA_W / 8;

    logic [7:0]        mem [MEM_BYTES];
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] word_c;

    assign idx   = addr[AW-1:0];
    assign oob_c = addr > DATA_W'(MEM_BYTES - NB);

    always_comb begin
        word_c = '0;
        for (int i = 0; i < int'(NB); i++) begin
            word_c[8*i +: 8] = mem[idx + AW'(i)];
        end
    end

    // Contents survive reset; only the read register is cleared
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < int'(NB); i++) begin
                mem[idx + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (access) begin
            rdata <= rd ? word_c : '0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Y86-64 SEQ memory stage: captures execute results, performs one data
// memory access, reports valM/stat and halts after any non-AOK status.
module mem_stage
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned DATA_W    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valP,
    input  logic              imem_error,
    input  logic              func_error,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] valM,
    output logic [1:0]        stat,
    output logic              dmem_error,
    output logic [3:0]        icode_o,
    output logic [DATA_W-1:0] valE_o
);

    state_t            state, state_nxt;
    mem_req_t          req;
    logic              accept_c, access_c, mem_op_c, rd_c, wr_en_c, oob_c;
    logic [DATA_W-1:0] addr_c, wdata_c;
    logic [1:0]        stat_c;

    assign icode_o = req.icode;
    assign valE_o  = req.valE;

    // Access decode, status priority and next state
    always_comb begin
        state_nxt = state;
        accept_c  = in_valid && in_ready;
        access_c  = (state == ST_ACCESS);
        mem_op_c  = is_mem(req.icode);
        addr_c    = addr_from_vala(req.icode) ? req.valA : req.valE;
        wdata_c   = (req.icode == ICALL) ? req.valP : req.valA;

        if (req.imem_error || (mem_op_c && oob_c)) begin
            stat_c = STAT_ADR;
        end else if (req.func_error) begin
            stat_c = STAT_INS;
        end else if (req.icode == IHALT) begin
            stat_c = STAT_HLT;
        end else begin
            stat_c = STAT_AOK;
        end

        rd_c    = is_read(req.icode) && (stat_c == STAT_AOK);
        wr_en_c = access_c && is_write(req.icode) && (stat_c == STAT_AOK);

        case (state)
            ST_IDLE:   if (accept_c) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   if (out_ready) state_nxt = (stat == STAT_AOK) ? ST_IDLE : ST_HALTED;
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            req        <= '0;
            stat       <= STAT_AOK;
            dmem_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == ST_IDLE);
            out_valid <= (state_nxt == ST_RESP);
            if (accept_c) begin
                req.icode      <= icode;
                req.valE       <= valE;
                req.valA       <= valA;
                req.valP       <= valP;
                req.imem_error <= imem_error;
                req.func_error <= func_error;
            end
            if (access_c) begin
                stat       <= stat_c;
                dmem_error <= mem_op_c && oob_c;
            end
        end
    end

    data_mem #(
        .MEM_BYTES(MEM_BYTES),
        .DATA_W   (DATA_W)
    ) u_dmem (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr_c),
        .wdata (wdata_c),
        .wr_en (wr_en_c),
        .access(access_c),
        .rd    (rd_c),
        .oob_c (oob_c),
        .rdata (valM)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized transactions
// checked against a byte-array memory model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [63:0] valE, valA, valP;
    logic        imem_error, func_error;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] valM;
    logic [1:0]  stat;
    logic        dmem_error;
    logic [3:0]  icode_o;
    logic [63:0] valE_o;

    int vectors = 0;
    int miscompares = 0;
    logic halted;

    logic [7:0] mdl [1024];

    mem_stage #(.MEM_BYTES(1024), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .valE(valE), .valA(valA), .valP(valP),
        .imem_error(imem_error), .func_error(func_error),
        .out_valid(out_valid), .out_ready(out_ready), .valM(valM), .stat(stat),
        .dmem_error(dmem_error), .icode_o(icode_o), .valE_o(valE_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory-stage rules applied to a flat byte array
    task automatic model(input logic [3:0] ic, input logic [63:0] e, a, p,
                         input logic ie, fe,
                         output logic [1:0] st, output logic err, output logic [63:0] m);
        logic [63:0] addr, data;
        logic        memop;
        int          base;
        memop = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        addr  = (ic == 4'h9 || ic == 4'hB) ? a : e;
        data  = (ic == 4'h8) ? p : a;
        err   = memop && (addr > 64'd1016);
        if (ie || err)      st = 2'd2;
        else if (fe)        st = 2'd3;
        else if (ic == 4'h0) st = 2'd1;
        else                st = 2'd0;
        m = '0;
        if (st == 2'd0 && memop) begin
            base = int'(addr[31:0]);
            if (ic inside {4'h5, 4'h9, 4'hB}) begin
                for (int i = 0; i < 8; i++) m[8*i +: 8] = mdl[base + i];
            end else begin
                for (int i = 0; i < 8; i++) mdl[base + i] = data[8*i +: 8];
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stat"},      64'(stat),       64'd0);
        chk({tag, "_valM"},      valM,            64'd0);
        chk({tag, "_dmem"},      64'(dmem_error), 64'd0);
        chk({tag, "_icode_o"},   64'(icode_o),    64'd0);
        chk({tag, "_valE_o"},    valE_o,          64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid),  64'd0);
        chk({tag, "_in_ready"},  64'(in_ready),   64'd1);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        halted = 1'b0;
    endtask

    task automatic txn(input logic [3:0] ic, input logic [63:0] e, a, p,
                       input logic ie, fe, input int hold);
        logic [1:0]  est;
        logic        eerr;
        logic [63:0] em;
        int          waitc;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            step();
            waitc++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        model(ic, e, a, p, ie, fe, est, eerr, em);
        icode = ic; valE = e; valA = a; valP = p;
        imem_error = ie; func_error = fe;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("access_out_valid", 64'(out_valid), 64'd0);
        chk("access_in_ready",  64'(in_ready),  64'd0);
        step();
        chk("resp_out_valid", 64'(out_valid),  64'd1);
        chk("resp_stat",      64'(stat),       64'(est));
        chk("resp_valM",      valM,            em);
        chk("resp_dmem",      64'(dmem_error), 64'(eerr));
        chk("resp_icode_o",   64'(icode_o),    64'(ic));
        chk("resp_valE_o",    valE_o,          e);
        for (int k = 0; k < hold; k++) begin
            step();
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready",  64'(in_ready),  64'd0);
            chk("hold_valM",      valM,           em);
            chk("hold_stat",      64'(stat),      64'(est));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_out_valid", 64'(out_valid), 64'd0);
        chk("post_in_ready",  64'(in_ready),  64'(est == 2'd0));
        halted = (est != 2'd0);
    endtask

    // After a non-AOK result the stage must stay closed until reset
    task automatic halt_and_reset();
        step();
        step();
        chk("halted_in_ready",  64'(in_ready),  64'd0);
        chk("halted_out_valid", 64'(out_valid), 64'd0);
        do_reset();
    endtask

    initial begin
        logic [63:0] v32, addr, ra, re, rp;
        logic [3:0]  ric;
        int          r;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        icode = '0; valE = '0; valA = '0; valP = '0;
        imem_error = 1'b0; func_error = 1'b0; halted = 1'b0;
        #12;
        chk_reset_outputs("initial");
        rst_n = 1'b1;
        step();

        // Fill low memory so later reads are fully defined
        for (int j = 0; j < 32; j++) begin
            txn(4'h4, 64'(j * 8), {$urandom, $urandom}, 64'd0, 1'b0, 1'b0, 0);
        end

        // rmmovq / mrmovq round trip, then an unaligned read for byte order
        txn(4'h4, 64'd16, 64'h1122334455667788, 64'd0, 1'b0, 1'b0, 0);
        txn(4'h5, 64'd16, 64'd0, 64'd0, 1'b0, 1'b0, 0);
        txn(4'h5, 64'd9, 64'd0, 64'd0, 1'b0, 1'b0, 0);

        // Backpressure on a read
        txn(4'h5, 64'd16, 64'd0, 64'd0, 1'b0, 1'b0, 3);

        // pushq at the top word, popq back through valA
        txn(4'hA, 64'd1016, 64'd7, 64'd0, 1'b0, 1'b0, 0);
        txn(4'hB, 64'd0, 64'd1016, 64'd0, 1'b0, 1'b0, 1);

        // call one byte past the last valid word
        txn(4'h8, 64'd1017, 64'd0, 64'h40, 1'b0, 1'b0, 0);
        halt_and_reset();
        txn(4'h5, 64'd1016, 64'd0, 64'd0, 1'b0, 1'b0, 0);

        // Address wider than the memory index must still be out of range
        txn(4'h4, 64'hFFFF_FFFF_FFFF_FFF8, 64'd5, 64'd0, 1'b0, 1'b0, 0);
        halt_and_reset();

        // halt, status priority
        txn(4'h0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 0);
        halt_and_reset();
        txn(4'h6, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 0);
        halt_and_reset();
        txn(4'h1, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 0);
        halt_and_reset();

        // Reset landing in ACCESS must cancel the pending write
        v32 = 64'hA5A5_0102_0304_5A5A;
        txn(4'h4, 64'd32, v32, 64'd0, 1'b0, 1'b0, 0);
        icode = 4'h4; valE = 64'd32; valA = 64'hDEAD_BEEF_CAFE_F00D; valP = '0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_in_access");
        step();
        rst_n = 1'b1;
        step();
        txn(4'h5, 64'd32, 64'd0, 64'd0, 1'b0, 1'b0, 0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            ric = 4'($urandom_range(0, 11));
            r   = int'($urandom_range(0, 15));
            if (r == 0)      addr = 64'(1017 + $urandom_range(0, 6));
            else if (r == 1) addr = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            else             addr = 64'($urandom_range(0, 248));
            ra = {$urandom, $urandom};
            re = {$urandom, $urandom};
            rp = {$urandom, $urandom};
            if (ric == 4'h9 || ric == 4'hB) ra = addr;
            else                            re = addr;
            txn(ric, re, ra, rp, ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                int'($urandom_range(0, 2)));
            if (halted) halt_and_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
